pingpong_ctrl: RTL and testbench
================================

// Module: pingpong_ctrl
// PURPOSE
//   Game core of the LED table-tennis design. Consumes the one-cycle key pulses from the debounced key scanner.
//   Runs serve/rally/score FSM; moves a one-hot ball along an LED row at a fixed step rate; keeps both players' scores.
//   Drives the LED row and score outputs for the display stage.
// PARAMETERS
//   N_LED        8           LEDs in row; led[N_LED-1] = P1 end, led[0] = P2 end (>=3)
//   STEP_CYCLES  12_500_000  clk cycles per ball step (0.25 s at 50 MHz)
//   WIN_SCORE    11          points that end a game (1..15)
// PORTS
//   clk          in   1        system clock, 50 MHz
//   rst_n        in   1        asynchronous active-low reset
//   key_flag     in   4        1-cycle pulses: [3] P1 hit, [2] new game, [1] pause toggle, [0] P2 hit
//   led          out  N_LED    ball position, one-hot; all ones in GAME_OVER
//   score1       out  4        P1 score, binary
//   score2       out  4        P2 score, binary
//   point_pulse  out  1        1-cycle pulse when either score increments
//   winner       out  2        00 none, 01 P1, 10 P2
//   paused       out  1        high while pause active
// BEHAVIOUR
//   Clocking/reset:
//     - One clock. Reset is asynchronous, active-low.
//     - All outputs registered.
//     - Reset values: state=SERVE, server=P1, pos=N_LED-1, led=1<<(N_LED-1), score1=score2=0, point_pulse=0, winner=00, paused=0, step counter=0.
//   Latency: key_flag pulse -> state/led/score change visible on the next clock edge (1 cycle).
//   Step tick:
//     - Counter runs 0..STEP_CYCLES-1 in TO_P1/TO_P2 only, when not paused.
//     - tick = (cnt==STEP_CYCLES-1).
//     - Counter clears on launch, on every return, on entering SERVE; it holds while paused.
//   States:
//     SERVE  : ball at server's end (pos=N_LED-1 for P1, 0 for P2).
//              Server's hit -> TO_P2 (P1 served) or TO_P1 (P2 served).
//              Receiver's hit is ignored.
//     TO_P2  : tick with pos>0 -> pos-1.
//              key_flag[0] with pos==0 -> TO_P1 (valid return).
//              key_flag[0] with pos>0 -> early hit, P1 scores -> POINT.
//              tick with pos==0, no hit -> miss, P1 scores -> POINT.
//              key_flag[3] ignored.
//     TO_P1  : mirror of TO_P2 (pos+1 toward N_LED-1, key_flag[3], P2 scores).
//     POINT  : 1 cycle. Winner's score +1; point_pulse=1.
//              If new score==WIN_SCORE -> GAME_OVER and set winner.
//              Otherwise -> SERVE with server = loser of the point, pos at server's end.
//     GAME_OVER : led all ones; scores frozen; only key_flag[2] has effect.
//   Priority and boundary rules:
//     - key_flag[2] has highest priority in every state, paused or not:
//       scores=0, winner=00, paused=0, server=P1, -> SERVE.
//     - key_flag[1] toggles paused in TO_P1/TO_P2 only; ignored elsewhere.
//     - While paused, hit keys and ticks are ignored and pos holds.
//     - Hit and tick in the same cycle at the end LED: the hit wins (valid return).
//     - Both hit keys in the same cycle: each evaluated per the state rules above; the non-addressed key is ignored.
//     - Scores never exceed WIN_SCORE; no wrap.
//     - Reset mid-rally returns everything to reset values immediately.
// STRUCTURE
//   - Package pingpong_pkg holds:
//       state enum {SERVE, TO_P2, TO_P1, POINT, GAME_OVER};
//       player enum {P1, P2};
//       KEY_P1=3, KEY_NEW=2, KEY_PAUSE=1, KEY_P2=0 bit indices.
//   - One sub-module, step_timer: parameterised STEP_CYCLES counter with clr and en inputs, registered tick output.
//   - FSM, position register and score logic stay in pingpong_ctrl.
// TESTING (N_LED=4, STEP_CYCLES=4, WIN_SCORE=3)
//   1. Reset, then P1 pulse -> TO_P2; led 1000 -> 0100 -> 0010 -> 0001, one step every 4 clks.
//   2. At led=0001, key_flag[0] in the tick cycle -> TO_P1, no point; led steps to 0010.
//   3. led=0001, no hit, tick -> score1=1, point_pulse for 1 cycle; next state SERVE, server P2, led=0001.
//   4. key_flag[0] at led=0100 (early) -> score1 +1; key_flag[3] during TO_P2 -> no effect.
//   5. P1 wins 3 points -> winner=01, led=1111, hits ignored; key_flag[2] -> scores 0, led=1000, SERVE.
//   6. Pause mid-rally for 20 clks -> pos and cnt frozen; unpause -> step resumes at frozen count.
//      Separately, rst_n low mid-rally -> reset values asynchronously.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared types and key-bit indices for the LED table-tennis game core.
package pingpong_pkg;

   typedef enum logic [2:0] {SERVE, TO_P2, TO_P1, POINT, GAME_OVER} state_e;
   typedef enum logic {P1, P2} player_e;

   localparam int KEY_P1    = 3;
   localparam int KEY_NEW   = 2;
   localparam int KEY_PAUSE = 1;
   localparam int KEY_P2    = 0;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pingpong_ctrl_step_timer.sv
// Ball step timer: counts 0..STEP_CYCLES-1 while enabled; tick is high exactly
// while the count sits at its last value, and holds along with the count when disabled.
module step_timer #(
   parameter int STEP_CYCLES = 12_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick_q;

   assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

   // tick is precomputed from the next count so it is registered yet aligned with cnt_q==LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (clr) begin
         cnt_q  <= '0;
         tick_q <= (LAST == '0);
      end else if (en) begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_d == LAST);
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/pingpong_ctrl.sv
// Table-tennis game core: serve/rally/point FSM, one-hot ball position,
// score keeping and pause handling, all outputs registered.
module pingpong_ctrl
   import pingpong_pkg::*;
#(
   parameter int N_LED       = 8,
   parameter int STEP_CYCLES = 12_500_000,
   parameter int WIN_SCORE   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       key_flag,
   output logic [N_LED-1:0] led,
   output logic [3:0]       score1,
   output logic [3:0]       score2,
   output logic             point_pulse,
   output logic [1:0]       winner,
   output logic             paused
);

   localparam int PW = $clog2(N_LED);
   localparam logic [PW-1:0] POS_P1 = PW'(N_LED - 1);
   localparam logic [PW-1:0] POS_P2 = '0;
   localparam logic [3:0]    WIN    = 4'(WIN_SCORE);

   state_e           state_q;
   player_e          server_q;
   player_e          pt_win_q;
   logic [PW-1:0]    pos_q;
   logic [N_LED-1:0] led_q;
   logic [3:0]       score1_q;
   logic [3:0]       score2_q;
   logic             pulse_q;
   logic [1:0]       winner_q;
   logic             paused_q;

   logic in_rally;
   logic run;
   logic ret_hit;
   logic tick;

   function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
      return N_LED'(1) << p;
   endfunction

   assign in_rally = (state_q == TO_P1) || (state_q == TO_P2);
   assign run      = in_rally && !paused_q;
   assign ret_hit  = run && (((state_q == TO_P2) && key_flag[KEY_P2] && (pos_q == POS_P2)) ||
                             ((state_q == TO_P1) && key_flag[KEY_P1] && (pos_q == POS_P1)));

   step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!in_rally || key_flag[KEY_NEW] || ret_hit),
      .en    (run),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SERVE;
         server_q <= P1;
         pt_win_q <= P1;
         pos_q    <= POS_P1;
         led_q    <= onehot(POS_P1);
         score1_q <= '0;
         score2_q <= '0;
         pulse_q  <= 1'b0;
         winner_q <= WIN_NONE;
         paused_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (key_flag[KEY_NEW]) begin
            state_q  <= SERVE;
            server_q <= P1;
            pos_q    <= POS_P1;
            led_q    <= onehot(POS_P1);
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WIN_NONE;
            paused_q <= 1'b0;
         end else begin
            unique case (state_q)
               SERVE: begin
                  if (server_q == P1 && key_flag[KEY_P1]) state_q <= TO_P2;
                  else if (server_q == P2 && key_flag[KEY_P2]) state_q <= TO_P1;
               end
               TO_P2: begin
                  if (key_flag[KEY_PAUSE]) paused_q <= !paused_q;
                  if (!paused_q && (key_flag[KEY_P2] || tick)) begin
                     // A hit outranks a same-cycle tick; only a hit at the end LED is a return.
                     if (key_flag[KEY_P2] && pos_q == POS_P2) begin
                        state_q <= TO_P1;
                     end else if (!key_flag[KEY_P2] && pos_q != POS_P2) begin
                        pos_q <= pos_q - 1'b1;
                        led_q <= onehot(pos_q - 1'b1);
                     end else begin
                        state_q  <= POINT;
                        pt_win_q <= P1;
                        if (score1_q != WIN) begin
                           score1_q <= score1_q + 1'b1;
                           pulse_q  <= 1'b1;
                        end
                     end
                  end
               end
               TO_P1: begin
                  if (key_flag[KEY_PAUSE]) paused_q <= !paused_q;
                  if (!paused_q && (key_flag[KEY_P1] || tick)) begin
                     if (key_flag[KEY_P1] && pos_q == POS_P1) begin
                        state_q <= TO_P2;
                     end else if (!key_flag[KEY_P1] && pos_q != POS_P1) begin
                        pos_q <= pos_q + 1'b1;
                        led_q <= onehot(pos_q + 1'b1);
                     end else begin
                        state_q  <= POINT;
                        pt_win_q <= P2;
                        if (score2_q != WIN) begin
                           score2_q <= score2_q + 1'b1;
                           pulse_q  <= 1'b1;
                        end
                     end
                  end
               end
               POINT: begin
                  if (((pt_win_q == P1) ? score1_q : score2_q) == WIN) begin
                     state_q  <= GAME_OVER;
                     winner_q <= (pt_win_q == P1) ? WIN_P1 : WIN_P2;
                     led_q    <= '1;
                  end else begin
                     // The player who lost the point serves next.
                     state_q  <= SERVE;
                     server_q <= (pt_win_q == P1) ? P2 : P1;
                     pos_q    <= (pt_win_q == P1) ? POS_P2 : POS_P1;
                     led_q    <= onehot((pt_win_q == P1) ? POS_P2 : POS_P1);
                  end
               end
               GAME_OVER: ;
               default: state_q <= SERVE;
            endcase
         end
      end
   end

   assign led         = led_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign point_pulse = pulse_q;
   assign winner      = winner_q;
   assign paused      = paused_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed table-driven bench for pingpong_ctrl with N_LED=4, STEP_CYCLES=4, WIN_SCORE=3.
module tb_pingpong_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_flag;
   logic [3:0] led;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       point_pulse;
   logic [1:0] winner;
   logic       paused;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] key;
      int         ncyc;
      logic [3:0] led;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       pp;
      logic [1:0] win;
      logic       pau;
   } vec_t;

   vec_t vq[$];

   pingpong_ctrl #(.N_LED(4), .STEP_CYCLES(4), .WIN_SCORE(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_flag    (key_flag),
      .led         (led),
      .score1      (score1),
      .score2      (score2),
      .point_pulse (point_pulse),
      .winner      (winner),
      .paused      (paused)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pk(input logic [3:0] l, input logic [3:0] a, input logic [3:0] b,
                                      input logic p, input logic [1:0] w, input logic z);
      return {l, a, b, p, w, z};
   endfunction

   task automatic check(input string name, input logic [15:0] exp);
      logic [15:0] got;
      got = {led, score1, score2, point_pulse, winner, paused};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got led=%b s1=%0d s2=%0d pp=%b win=%b pau=%b, want led=%b s1=%0d s2=%0d pp=%b win=%b pau=%b",
                  name, got[15:12], got[11:8], got[7:4], got[3], got[2:1], got[0],
                  exp[15:12], exp[11:8], exp[7:4], exp[3], exp[2:1], exp[0]);
      end else begin
         $display("ok   %s: led=%b s1=%0d s2=%0d pp=%b win=%b pau=%b",
                  name, got[15:12], got[11:8], got[7:4], got[3], got[2:1], got[0]);
      end
   endtask

   // Called at a negedge: key held for one cycle, n rising edges, returns at a negedge.
   task automatic step(input logic [3:0] k, input int n);
      key_flag = k;
      @(posedge clk);
      #1 key_flag = '0;
      for (int i = 1; i < n; i++) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic [3:0] k, input int n, input logic [3:0] l, input logic [3:0] a,
                      input logic [3:0] b, input logic p, input logic [1:0] w, input logic z);
      vec_t v;
      v.key = k; v.ncyc = n; v.led = l; v.s1 = a; v.s2 = b; v.pp = p; v.win = w; v.pau = z;
      vq.push_back(v);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      // Rally P1->P2 end, tick+hit return, P1 end return, miss at P2 end
      add(4'b1000, 1, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0100, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0010, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0001, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 3, 4'b0001, 0, 0, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b0001, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0010, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0100, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b1000, 1, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0100, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0010, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0001, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0001, 1, 0, 1, 2'b00, 0);
      add(4'b0000, 1, 4'b0001, 1, 0, 0, 2'b00, 0);
      // P2 serves, receiver and non-addressed keys ignored, early hits
      add(4'b1000, 1, 4'b0001, 1, 0, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b0001, 1, 0, 0, 2'b00, 0);
      add(4'b0000, 4, 4'b0010, 1, 0, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b0010, 1, 0, 0, 2'b00, 0);
      add(4'b1000, 1, 4'b0010, 1, 1, 1, 2'b00, 0);
      add(4'b0000, 1, 4'b1000, 1, 1, 0, 2'b00, 0);
      add(4'b1001, 1, 4'b1000, 1, 1, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b1000, 2, 1, 1, 2'b00, 0);
      add(4'b0000, 1, 4'b0001, 2, 1, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b0001, 2, 1, 0, 2'b00, 0);
      add(4'b1000, 1, 4'b0001, 2, 2, 1, 2'b00, 0);
      add(4'b0000, 1, 4'b1000, 2, 2, 0, 2'b00, 0);
      // P1 reaches WIN_SCORE, game over, new game
      add(4'b1000, 1, 4'b1000, 2, 2, 0, 2'b00, 0);
      add(4'b0001, 1, 4'b1000, 3, 2, 1, 2'b00, 0);
      add(4'b0000, 1, 4'b1111, 3, 2, 0, 2'b01, 0);
      add(4'b1001, 1, 4'b1111, 3, 2, 0, 2'b01, 0);
      add(4'b0010, 1, 4'b1111, 3, 2, 0, 2'b01, 0);
      add(4'b0100, 1, 4'b1000, 0, 0, 0, 2'b00, 0);
      // Pause freezes position and count, resumes at the frozen count
      add(4'b1000, 1, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 2, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b0010, 1, 4'b1000, 0, 0, 0, 2'b00, 1);
      add(4'b0000, 20, 4'b1000, 0, 0, 0, 2'b00, 1);
      add(4'b0001, 1, 4'b1000, 0, 0, 0, 2'b00, 1);
      add(4'b0010, 1, 4'b1000, 0, 0, 0, 2'b00, 0);
      add(4'b0000, 1, 4'b0100, 0, 0, 0, 2'b00, 0);
      add(4'b0010, 1, 4'b0100, 0, 0, 0, 2'b00, 1);
      add(4'b0100, 1, 4'b1000, 0, 0, 0, 2'b00, 0);

      rst_n    = 1'b0;
      key_flag = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset", pk(4'b1000, 0, 0, 0, 2'b00, 0));

      foreach (vq[i]) begin
         step(vq[i].key, vq[i].ncyc);
         check($sformatf("vec%0d", i),
               pk(vq[i].led, vq[i].s1, vq[i].s2, vq[i].pp, vq[i].win, vq[i].pau));
      end

      // Asynchronous reset in the middle of a paused rally with a nonzero score
      step(4'b1000, 1);
      step(4'b0001, 1);
      step(4'b0000, 1);
      step(4'b0001, 1);
      step(4'b0010, 1);
      check("pre_reset", pk(4'b0001, 1, 0, 0, 2'b00, 1));
      #2 rst_n = 1'b0;
      #1 check("async_reset", pk(4'b1000, 0, 0, 0, 2'b00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0001, 1);
      check("server_p1_after_reset", pk(4'b1000, 0, 0, 0, 2'b00, 0));
      step(4'b1000, 1);
      step(4'b0000, 4);
      check("rally_after_reset", pk(4'b0100, 0, 0, 0, 2'b00, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
